riscv_imem_arb: RTL and testbench

Arbiter and access sequencer for the single-port instruction memory. It shares the memory between two requesters: the core fetch unit (read-only) and the debug/loader port (read/write). It serialises accesses, applies the fixed memory latency with a counter, and returns a one-cycle response pulse per granted request. Word-misaligned requests are rejected with an error response and never reach the memory.

---
 rtl/riscv_imem_arb.sv | 197 +++++++++++++++++++
 tb/tb_riscv_imem_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_imem_arb.sv
// Instruction-memory arbiter: shares one single-port memory between the fetch unit
// and the debug/loader port, applying a fixed access latency and one response per grant.
module riscv_imem_arb #(
   parameter int INST_WIDTH = 32,
   parameter int PC_WIDTH   = 15,
   parameter int MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  f_req,
   input  logic [PC_WIDTH-1:0]   f_addr,
   output logic                  f_gnt,
   output logic                  f_rvalid,
   output logic [INST_WIDTH-1:0] f_rdata,
   output logic                  f_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [PC_WIDTH-1:0]   d_addr,
   input  logic [INST_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [INST_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [PC_WIDTH-3:0]   mem_addr,
   output logic [INST_WIDTH-1:0] mem_wdata,
   input  logic [INST_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  rr_q, rr_d;       // 1: debug wins the next tie
   logic                  own_q, own_d;     // 1: current access belongs to debug
   logic                  f_gnt_q, f_gnt_d;
   logic                  d_gnt_q, d_gnt_d;
   logic                  f_rvalid_q, f_rvalid_d;
   logic                  d_rvalid_q, d_rvalid_d;
   logic [INST_WIDTH-1:0] f_rdata_q, f_rdata_d;
   logic [INST_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  f_err_q, f_err_d;
   logic                  d_err_q, d_err_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [PC_WIDTH-3:0]   mem_addr_q, mem_addr_d;
   logic [INST_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic                  f_req_v;
   logic                  d_req_v;
   logic                  pick_dbg;
   logic                  arb_go;
   logic [PC_WIDTH-1:0]   sel_addr;
   logic                  sel_we;
   logic [INST_WIDTH-1:0] sel_wdata;
   logic [INST_WIDTH-1:0] resp_data;

   // A requester still holds req during its own grant cycle; that belongs to
   // the request already granted and must not be arbitrated a second time.
   assign f_req_v   = f_req & ~f_gnt_q;
   assign d_req_v   = d_req & ~d_gnt_q;
   assign pick_dbg  = d_req_v & (~f_req_v | rr_q);
   assign arb_go    = (state_q != ACCESS) & (f_req_v | d_req_v);
   assign sel_addr  = pick_dbg ? d_addr : f_addr;
   assign sel_we    = pick_dbg & d_we;
   assign sel_wdata = pick_dbg ? d_wdata : '0;
   assign resp_data = mem_we_q ? '0 : mem_rdata;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      own_d       = own_q;
      f_gnt_d     = 1'b0;
      d_gnt_d     = 1'b0;
      f_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      f_rdata_d   = f_rdata_q;
      d_rdata_d   = d_rdata_q;
      f_err_d     = f_err_q;
      d_err_d     = d_err_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ACCESS: begin
            if (cnt_q == 3'd1) begin
               state_d = RESP;
               cnt_d   = 3'd0;
               if (own_q) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = resp_data;
                  d_err_d    = 1'b0;
               end else begin
                  f_rvalid_d = 1'b1;
                  f_rdata_d  = resp_data;
                  f_err_d    = 1'b0;
               end
            end else begin
               cnt_d    = cnt_q - 3'd1;
               mem_en_d = 1'b1;
               mem_we_d = mem_we_q;
            end
         end
         default: begin
            state_d = IDLE;
            if (arb_go) begin
               own_d   = pick_dbg;
               rr_d    = ~pick_dbg;
               f_gnt_d = ~pick_dbg;
               d_gnt_d = pick_dbg;
               if (sel_addr[1:0] == 2'b00) begin
                  state_d     = ACCESS;
                  cnt_d       = LAT_INIT;
                  mem_en_d    = 1'b1;
                  mem_we_d    = sel_we;
                  mem_addr_d  = sel_addr[PC_WIDTH-1:2];
                  mem_wdata_d = sel_wdata;
               end else begin
                  // Misaligned: answer immediately, memory is never touched.
                  state_d = RESP;
                  if (pick_dbg) begin
                     d_rvalid_d = 1'b1;
                     d_rdata_d  = '0;
                     d_err_d    = 1'b1;
                  end else begin
                     f_rvalid_d = 1'b1;
                     f_rdata_d  = '0;
                     f_err_d    = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         rr_q        <= 1'b0;
         own_q       <= 1'b0;
         f_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         f_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
         f_err_q     <= 1'b0;
         d_err_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         own_q       <= own_d;
         f_gnt_q     <= f_gnt_d;
         d_gnt_q     <= d_gnt_d;
         f_rvalid_q  <= f_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         f_rdata_q   <= f_rdata_d;
         d_rdata_q   <= d_rdata_d;
         f_err_q     <= f_err_d;
         d_err_q     <= d_err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign f_gnt     = f_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign f_rvalid  = f_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign f_err     = f_err_q;
   assign d_err     = d_err_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_riscv_imem_arb.sv
// Directed bench for riscv_imem_arb: three instances with MEM_LAT = 1, 3 and 7,
// each backed by a small combinational-read memory model.
module tb_riscv_imem_arb;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic        f_req     [3];
   logic [14:0] f_addr    [3];
   logic        f_gnt     [3];
   logic        f_rvalid  [3];
   logic [31:0] f_rdata   [3];
   logic        f_err     [3];
   logic        d_req     [3];
   logic        d_we      [3];
   logic [14:0] d_addr    [3];
   logic [31:0] d_wdata   [3];
   logic        d_gnt     [3];
   logic        d_rvalid  [3];
   logic [31:0] d_rdata   [3];
   logic        d_err     [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [12:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];
   bit          last_dbg  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [31:0] mem [256];
      logic [31:0] rdata_g;

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
         mem[4] = 32'h0050_0093;
      end
      always @(posedge clk) if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
      assign rdata_g = mem[mem_addr[g][7:0]];

      riscv_imem_arb #(
         .INST_WIDTH(32),
         .PC_WIDTH  (15),
         .MEM_LAT   ((g == 0) ? 1 : ((g == 1) ? 3 : 7))
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .f_req    (f_req[g]),
         .f_addr   (f_addr[g]),
         .f_gnt    (f_gnt[g]),
         .f_rvalid (f_rvalid[g]),
         .f_rdata  (f_rdata[g]),
         .f_err    (f_err[g]),
         .d_req    (d_req[g]),
         .d_we     (d_we[g]),
         .d_addr   (d_addr[g]),
         .d_wdata  (d_wdata[g]),
         .d_gnt    (d_gnt[g]),
         .d_rvalid (d_rvalid[g]),
         .d_rdata  (d_rdata[g]),
         .d_err    (d_err[g]),
         .mem_en   (mem_en[g]),
         .mem_we   (mem_we[g]),
         .mem_addr (mem_addr[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_rdata(rdata_g)
      );
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
   endfunction

   task automatic check_zero(input int k, input string tag);
      check({tag, "_gnt"},    32'({f_gnt[k], d_gnt[k]}), 32'd0);
      check({tag, "_rvalid"}, 32'({f_rvalid[k], d_rvalid[k]}), 32'd0);
      check({tag, "_err"},    32'({f_err[k], d_err[k]}), 32'd0);
      check({tag, "_f_rdata"}, f_rdata[k], 32'd0);
      check({tag, "_d_rdata"}, d_rdata[k], 32'd0);
      check({tag, "_mem_ctl"}, 32'({mem_en[k], mem_we[k]}), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr[k]), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata[k], 32'd0);
   endtask

   // One request from fetch (dbg=0) or debug (dbg=1), checked from grant to response.
   task automatic run_req(input int k, input bit dbg, input bit we, input logic [14:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
      int lat, cyc, n_en;
      logic rv;
      lat = lat_of(k);
      @(negedge clk);
      if (dbg) begin
         d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
      end else begin
         f_req[k] = 1'b1; f_addr[k] = addr;
      end
      @(posedge clk); #1;
      check("gnt", 32'(dbg ? d_gnt[k] : f_gnt[k]), 32'd1);
      check("other_gnt", 32'(dbg ? f_gnt[k] : d_gnt[k]), 32'd0);
      f_req[k] = 1'b0;
      d_req[k] = 1'b0;
      last_dbg[k] = dbg;
      n_en = 0;
      cyc  = 0;
      rv   = dbg ? d_rvalid[k] : f_rvalid[k];
      if (mem_en[k]) begin
         n_en++;
         check("mem_addr", 32'(mem_addr[k]), 32'(addr[14:2]));
         check("mem_we", 32'(mem_we[k]), 32'(dbg & we));
      end
      while (!rv && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         rv = dbg ? d_rvalid[k] : f_rvalid[k];
         if (mem_en[k]) begin
            n_en++;
            check("mem_addr", 32'(mem_addr[k]), 32'(addr[14:2]));
            check("mem_we", 32'(mem_we[k]), 32'(dbg & we));
         end
      end
      check("resp_lat", 32'(cyc), exp_err ? 32'd0 : 32'(lat));
      check("mem_en_cycles", 32'(n_en), exp_err ? 32'd0 : 32'(lat));
      check("rdata", dbg ? d_rdata[k] : f_rdata[k], exp_rd);
      check("err", 32'(dbg ? d_err[k] : f_err[k]), 32'(exp_err));
      check("other_rvalid", 32'(dbg ? f_rvalid[k] : d_rvalid[k]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_gr, n_rv, prev, cyc, n_en, lat;
      bit  exp_dbg, owner;

      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         f_req[k] = 1'b0; f_addr[k] = '0;
         d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
         last_dbg[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero(0, "rst0");
      check_zero(2, "rst2");
      @(negedge clk);
      reset = 1'b0;

      // Single fetch, debug write, read-back, misaligned fetch and debug read.
      run_req(0, 1'b0, 1'b0, 15'h0010, 32'h0, 32'h0050_0093, 1'b0);
      run_req(0, 1'b1, 1'b1, 15'h0020, 32'hDEAD_BEEF, 32'h0, 1'b0);
      run_req(0, 1'b0, 1'b0, 15'h0020, 32'h0, 32'hDEAD_BEEF, 1'b0);
      run_req(0, 1'b0, 1'b0, 15'h0012, 32'h0, 32'h0, 1'b1);
      run_req(0, 1'b1, 1'b0, 15'h0021, 32'h0, 32'h0, 1'b1);
      run_req(2, 1'b1, 1'b0, 15'h0010, 32'h0, 32'h0050_0093, 1'b0);

      // Contention on MEM_LAT=1: grants must alternate, responses go to their owner.
      exp_dbg = ~last_dbg[0];
      owner   = 1'b0;
      n_gr    = 0;
      @(negedge clk);
      f_req[0] = 1'b1; f_addr[0] = 15'h0010;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 15'h0020;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (f_gnt[0] || d_gnt[0]) begin
            check("cont_one_gnt", 32'(f_gnt[0] & d_gnt[0]), 32'd0);
            check("cont_order", 32'(d_gnt[0]), 32'(exp_dbg));
            owner   = d_gnt[0];
            exp_dbg = ~exp_dbg;
            n_gr++;
         end
         if (f_rvalid[0]) begin
            check("cont_f_owner", 32'(owner), 32'd0);
            check("cont_f_rdata", f_rdata[0], 32'h0050_0093);
         end
         if (d_rvalid[0]) begin
            check("cont_d_owner", 32'(owner), 32'd1);
            check("cont_d_rdata", d_rdata[0], 32'hDEAD_BEEF);
         end
      end
      check("cont_grants", 32'(n_gr), 32'd13);
      last_dbg[0] = owner;
      @(negedge clk);
      f_req[0] = 1'b0;
      d_req[0] = 1'b0;
      repeat (3) @(posedge clk);

      // Back-to-back fetches: spacing MEM_LAT+1, MEM_LAT enable cycles each.
      for (int k = 0; k < 3; k++) begin
         lat  = lat_of(k);
         n_rv = 0;
         prev = -1;
         cyc  = 0;
         n_en = 0;
         @(negedge clk);
         f_req[k] = 1'b1; f_addr[k] = 15'h0010;
         while (n_rv < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_en[k]) n_en++;
            if (f_rvalid[k]) begin
               if (prev >= 0) check("sweep_gap", 32'(cyc - prev), 32'(lat + 1));
               check("sweep_en", 32'(n_en), 32'(lat));
               check("sweep_rdata", f_rdata[k], 32'h0050_0093);
               n_en = 0;
               prev = cyc;
               n_rv++;
            end
         end
         check("sweep_count", 32'(n_rv), 32'd4);
         @(negedge clk);
         f_req[k] = 1'b0;
         last_dbg[k] = 1'b0;
         repeat (lat + 3) @(posedge clk);
      end

      // Asynchronous reset in the middle of a MEM_LAT=3 access.
      @(negedge clk);
      f_req[1] = 1'b1; f_addr[1] = 15'h0010;
      @(posedge clk); #1;
      check("rst_pre_gnt", 32'(f_gnt[1]), 32'd1);
      f_req[1] = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_access", 32'(mem_en[1]), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_zero(1, "rst_async");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) last_dbg[k] = 1'b1;
      n_rv = 0;
      repeat (8) begin
         @(posedge clk); #1;
         n_rv += int'(f_rvalid[1]) + int'(d_rvalid[1]);
      end
      check("rst_no_rvalid", 32'(n_rv), 32'd0);
      run_req(1, 1'b0, 1'b0, 15'h0010, 32'h0, 32'h0050_0093, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
